adc121s_spi_ctrl: RTL

SPI master for the ADC121S 12-bit serial ADC.
- Generates adc_cs_n and adc_sclk from the system clock and samples adc_sdata once per SCLK period.
- Assembles each 16-bit frame, checks it and presents a 12-bit sample with a one-cycle valid strobe.
- Sits directly upstream of the sample-consuming logic; the only block that drives the ADC pins.

---
 rtl/adc121s_spi_ctrl_if.sv | 23 ++
 rtl/adc121s_spi_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adc121s_spi_ctrl_if.sv
// Signal bundle between the ADC121S SPI controller, the ADC pins and the sample consumer.
// master: the controller side; slave: the environment (ADC pins and request/sample logic).
interface adc121s_spi_ctrl_if;
  logic        enable;
  logic        start;
  logic        adc_sdata;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  enable, start, adc_sdata,
    output adc_cs_n, adc_sclk, sample_data, sample_valid, frame_err, busy
  );

  modport slave (
    output enable, start, adc_sdata,
    input  adc_cs_n, adc_sclk, sample_data, sample_valid, frame_err, busy
  );
endinterface

// File: rtl/adc121s_spi_ctrl.sv
// SPI master for the ADC121S: CS/SCLK generation, 16-bit frame capture, 12-bit sample output.
// Optional macro ADC_SDATA_SYNC_EN adds a 2-flop synchronizer on adc_sdata (needs CLK_DIV >= 3).
module adc121s_spi_ctrl #(
  parameter int CLK_DIV        = 4,
  parameter int CS_HIGH_CYCLES = 8,
  parameter int FRAME_BITS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  adc121s_spi_ctrl_if.master   bus
);

  localparam int DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int HALF_N  = 2 * FRAME_BITS;
  localparam int HALF_W  = $clog2(HALF_N);
  localparam int QUIET_W = $clog2(CS_HIGH_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic [QUIET_W-1:0]    quiet_q, quiet_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [11:0]           data_q, data_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic sdata_cap;
  logic div_last;
  logic half_last;
  logic quiet_last;
  logic capture;
  logic load;

`ifdef ADC_SDATA_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.adc_sdata};
    end
  end

  assign sdata_cap = sync_q[1];
`else
  assign sdata_cap = bus.adc_sdata;
`endif

  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
  assign half_last  = (half_q == HALF_W'(HALF_N - 1));
  assign quiet_last = (quiet_q == QUIET_W'(CS_HIGH_CYCLES - 1));
  // Sample just before the falling edge that ends each SCLK-high half-period.
  assign capture    = (state_q == S_SHIFT) && half_q[0] && div_last;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    quiet_d = quiet_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start || bus.enable) begin
          state_d = S_SETUP;
          div_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (half_last) begin
            state_d = S_DONE;
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        quiet_d = '0;
      end
      S_QUIET: begin
        if (quiet_last) begin
          state_d = bus.enable ? S_SETUP : S_IDLE;
          div_d   = '0;
        end else begin
          quiet_d = quiet_q + QUIET_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin and sample registers are loaded from the next state so they line up with state_q.
  always_comb begin
    shift_d = capture ? {shift_q[FRAME_BITS-2:0], sdata_cap} : shift_q;
    load    = (state_q == S_SHIFT) && (state_d == S_DONE);
    data_d  = load ? shift_d[11:0] : data_q;
    err_d   = load ? (shift_d[15:12] != 4'd0) : err_q;
    valid_d = load;
    cs_n_d  = !((state_d == S_SETUP) || (state_d == S_SHIFT));
    sclk_d  = (state_d == S_SHIFT) ? half_d[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      quiet_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      quiet_q <= quiet_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
